// File: rtl/pwm_ramp_sequencer_if.sv
// Request/duty bundle between control logic (master) and the ramp sequencer (slave).
// Valid/ready request in, registered duty/busy/done status out.
interface pwm_ramp_sequencer_if #(
  parameter int DUTY_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DUTY_W-1:0] req_duty;
  logic              abort;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              done;

  modport master (
    output req_valid,
    output req_duty,
    output abort,
    input  req_ready,
    input  duty,
    input  busy,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_duty,
    input  abort,
    output req_ready,
    output duty,
    output busy,
    output done
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Walks duty one LSB per STEP_CYCLES clocks toward an accepted target; d*STEP_CYCLES latency.
// Requests accepted only in IDLE (req_ready low while ramping); abort forces duty to 0.
module pwm_ramp_sequencer #(
  parameter int DUTY_W      = 4,
  parameter int STEP_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_ramp_sequencer_if.slave   seq
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic              done_q, done_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  logic [DUTY_W-1:0] duty_stepped;
  logic              step_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      step_cnt_q  <= '0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      step_cnt_q  <= step_cnt_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    target_d     = target_q;
    step_cnt_d   = step_cnt_q;
    done_d       = 1'b0;
    step_edge    = (step_cnt_q == CNT_MAX);
    duty_stepped = (state_q == RAMP_DOWN) ? duty_q - DUTY_W'(1) : duty_q + DUTY_W'(1);

    if (seq.abort) begin
      // abort outranks a same-cycle accept and never reports completion
      state_d    = IDLE;
      duty_d     = '0;
      step_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq.req_valid) begin
            target_d   = seq.req_duty;
            step_cnt_d = '0;
            if (seq.req_duty > duty_q) begin
              state_d = RAMP_UP;
            end else if (seq.req_duty < duty_q) begin
              state_d = RAMP_DOWN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (step_edge) begin
            step_cnt_d = '0;
            duty_d     = duty_stepped;
            // duty only moves toward target, so reaching it ends the ramp without wrap
            if (duty_stepped == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          step_cnt_d = '0;
        end
      endcase
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign seq.duty      = duty_q;
  assign seq.done      = done_q;
  assign seq.req_ready = req_ready_q;
  assign seq.busy      = busy_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: STEP_CYCLES=4 instance plus a STEP_CYCLES=1 instance.
module tb_pwm_ramp_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pwm_ramp_sequencer_if #(.DUTY_W(4)) if4 ();
  pwm_ramp_sequencer_if #(.DUTY_W(4)) if1 ();

  pwm_ramp_sequencer #(.DUTY_W(4), .STEP_CYCLES(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .seq (if4.slave)
  );

  pwm_ramp_sequencer #(.DUTY_W(4), .STEP_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .seq (if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request 'to' on the STEP_CYCLES=4 instance from duty 'from' (from != to) and follow every clock.
  task automatic ramp4(input string t, input int from, input int to);
    int d;
    int n;
    int e;
    d = (to > from) ? to - from : from - to;
    n = d * 4;
    if4.req_valid = 1'b1;
    if4.req_duty  = 4'(to);
    tick();
    if4.req_valid = 1'b0;
    check({t, "_acc_busy"}, if4.busy, 1);
    check({t, "_acc_ready"}, if4.req_ready, 0);
    check({t, "_acc_duty"}, if4.duty, from);
    for (int k = 1; k <= n; k++) begin
      tick();
      e = (to > from) ? from + k / 4 : from - k / 4;
      check({t, "_duty"}, if4.duty, e);
      check({t, "_done"}, if4.done, (k == n) ? 1 : 0);
      check({t, "_ready"}, if4.req_ready, (k == n) ? 1 : 0);
      check({t, "_busy"}, if4.busy, (k == n) ? 0 : 1);
    end
    tick();
    check({t, "_done_clr"}, if4.done, 0);
    check({t, "_hold_duty"}, if4.duty, to);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    if4.req_valid = 1'b0;
    if4.req_duty  = '0;
    if4.abort     = 1'b0;
    if1.req_valid = 1'b0;
    if1.req_duty  = '0;
    if1.abort     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_duty", if4.duty, 0);
    check("rst_ready", if4.req_ready, 1);
    check("rst_busy", if4.busy, 0);
    check("rst_done", if4.done, 0);

    // 0 -> 5, then 5 -> 2
    ramp4("up5", 0, 5);
    ramp4("dn2", 5, 2);

    // equal target: no motion, one-cycle done
    if4.req_valid = 1'b1;
    if4.req_duty  = 4'd2;
    tick();
    if4.req_valid = 1'b0;
    check("eq_done", if4.done, 1);
    check("eq_busy", if4.busy, 0);
    check("eq_duty", if4.duty, 2);
    check("eq_ready", if4.req_ready, 1);
    tick();
    check("eq_done_clr", if4.done, 0);
    check("eq_duty2", if4.duty, 2);

    // abort from IDLE at duty 2, then abort at duty 0 is a no-op
    if4.abort = 1'b1;
    tick();
    if4.abort = 1'b0;
    check("abort_idle_duty", if4.duty, 0);
    check("abort_idle_done", if4.done, 0);
    if4.abort = 1'b1;
    tick();
    if4.abort = 1'b0;
    check("abort_nop_duty", if4.duty, 0);
    check("abort_nop_ready", if4.req_ready, 1);
    check("abort_nop_busy", if4.busy, 0);

    // 0 -> 15, abort with a competing request once duty reaches 7
    if4.req_valid = 1'b1;
    if4.req_duty  = 4'd15;
    tick();
    if4.req_valid = 1'b0;
    for (int k = 1; k <= 28; k++) tick();
    check("abort_pre_duty", if4.duty, 7);
    check("abort_pre_busy", if4.busy, 1);
    if4.abort     = 1'b1;
    if4.req_valid = 1'b1;
    if4.req_duty  = 4'd15;
    tick();
    if4.abort     = 1'b0;
    if4.req_valid = 1'b0;
    check("abort_duty", if4.duty, 0);
    check("abort_busy", if4.busy, 0);
    check("abort_ready", if4.req_ready, 1);
    check("abort_done", if4.done, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("abort_noacc_duty", if4.duty, 0);
      check("abort_noacc_busy", if4.busy, 0);
      check("abort_noacc_done", if4.done, 0);
    end

    // 0 -> 3 with a request for 9 held during the ramp
    if4.req_valid = 1'b1;
    if4.req_duty  = 4'd3;
    tick();
    if4.req_duty  = 4'd9;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("held_ready", if4.req_ready, (k == 12) ? 1 : 0);
      check("held_duty", if4.duty, k / 4);
    end
    check("held_done3", if4.done, 1);
    tick();
    if4.req_valid = 1'b0;
    check("held_acc_busy", if4.busy, 1);
    check("held_acc_ready", if4.req_ready, 0);
    check("held_acc_duty", if4.duty, 3);
    check("held_acc_done", if4.done, 0);
    for (int k = 1; k <= 23; k++) tick();
    check("held_pre_duty", if4.duty, 8);
    check("held_pre_done", if4.done, 0);
    tick();
    check("held_fin_duty", if4.duty, 9);
    check("held_fin_done", if4.done, 1);
    check("held_fin_busy", if4.busy, 0);

    // mid-cycle async reset during a 9 -> 6 ramp
    tick();
    if4.req_valid = 1'b1;
    if4.req_duty  = 4'd6;
    tick();
    if4.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check("mid_pre_duty", if4.duty, 8);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_duty", if4.duty, 0);
    check("mid_rst_ready", if4.req_ready, 1);
    check("mid_rst_busy", if4.busy, 0);
    check("mid_rst_done", if4.done, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_duty", if4.duty, 0);
    check("post_rst_busy", if4.busy, 0);

    // STEP_CYCLES=1: 0 -> 5, one step per clock
    if1.req_valid = 1'b1;
    if1.req_duty  = 4'd5;
    tick();
    if1.req_valid = 1'b0;
    check("s1_acc_duty", if1.duty, 0);
    check("s1_acc_busy", if1.busy, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("s1_duty", if1.duty, k);
      check("s1_done", if1.done, (k == 5) ? 1 : 0);
      check("s1_ready", if1.req_ready, (k == 5) ? 1 : 0);
    end
    tick();
    check("s1_done_clr", if1.done, 0);
    check("s1_hold_duty", if1.duty, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
